aes_key_sched_fwd: RTL and testbench

//  Forward AES key schedule (FIPS-197 KeyExpansion), word-serial: computes one 32-bit word per clock.

---
 rtl/aes_pkg.sv | 45 ++++
 rtl/aes_sub_word.sv | 13 +
 rtl/aes_key_sched_fwd.sv | 186 ++++++++++++++++++
 tb/tb_aes_key_sched_fwd.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers for the key-schedule blocks: S-box table, xtime,
// round-count helper and the key-schedule state encoding.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_t;

    // Entry 0x00 sits in the most significant byte.
    localparam logic [2047:0] AES_SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        logic [10:0] w_idx;
        w_idx = {~b, 3'b000};
        return AES_SBOX_TBL[w_idx +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int nr_of(input int key_size);
        return key_size / 32 + 6;
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups across a 32-bit word (combinational).
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    for (genvar g = 0; g < 4; g++) begin : g_byte
        assign o_word[8*g +: 8] = aes_sbox(i_word[8*g +: 8]);
    end

endmodule

// File: rtl/aes_key_sched_fwd.sv
// Word-serial forward AES key expansion into a flat round-key bank (kall).
// Define AES_KS_RK_STREAM_EN to add the per-round-key stream (rk_valid/rk_idx/rk).
module aes_key_sched_fwd
    import aes_pkg::*;
#(
    parameter int KEY_SIZE = 128
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [KEY_SIZE-1:0]                   key,
    output logic                                  busy,
    output logic                                  done,
    output logic [128*(nr_of(KEY_SIZE)+1)-1:0]    kall
`ifdef AES_KS_RK_STREAM_EN
    ,
    output logic                                  rk_valid,
    output logic [3:0]                            rk_idx,
    output logic [127:0]                          rk
`endif
);

    localparam int NK     = KEY_SIZE / 32;
    localparam int NR     = NK + 6;
    localparam int NW     = 4 * (NR + 1);
    localparam int KALL_W = 128 * (NR + 1);

    localparam logic [5:0] NK_I     = 6'(NK);
    localparam logic [5:0] LAST_I   = 6'(NW - 1);
    localparam logic [2:0] MOD_LAST = 3'(NK - 1);

    if (KEY_SIZE != 128 && KEY_SIZE != 192 && KEY_SIZE != 256) begin : g_bad_key_size
        $error("aes_key_sched_fwd: KEY_SIZE must be 128, 192 or 256");
    end

    // Bit offset of word w[j] inside kall: round j/4, word j%4 counted from the top.
    function automatic logic [10:0] word_lsb(input logic [5:0] j);
        return {j[5:2], ~j[1:0], 5'b00000};
    endfunction

    ks_state_t         r_state;
    ks_state_t         w_next_state;
    logic [5:0]        r_i;
    logic [2:0]        r_mod;
    logic [7:0]        r_rcon;
    logic              r_busy;
    logic              r_done;
    logic [KALL_W-1:0] r_kall;

    logic [KALL_W-1:0] w_load;
    logic [31:0]       w_prev;
    logic [31:0]       w_old;
    logic [31:0]       w_rot;
    logic [31:0]       w_sub_in;
    logic [31:0]       w_sub_out;
    logic [31:0]       w_temp;
    logic [31:0]       w_new;
    logic              w_last;

    assign busy = r_busy;
    assign done = r_done;
    assign kall = r_kall;

    always_comb begin
        w_load = '0;
        for (int k = 0; k < NK; k++) begin
            w_load[word_lsb(6'(k)) +: 32] = key[KEY_SIZE-1-32*k -: 32];
        end
    end

    // Both operands come straight out of the bank; no separate word store.
    assign w_prev   = r_kall[word_lsb(r_i - 6'd1) +: 32];
    assign w_old    = r_kall[word_lsb(r_i - NK_I) +: 32];
    assign w_rot    = {w_prev[23:0], w_prev[31:24]};
    assign w_sub_in = (r_mod == 3'd0) ? w_rot : w_prev;
    assign w_last   = (r_i == LAST_I);

    aes_sub_word u_sub_word (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    always_comb begin
        w_temp = w_prev;
        if (r_mod == 3'd0) begin
            w_temp = w_sub_out ^ {r_rcon, 24'h000000};
        end else if (NK == 8 && r_mod == 3'd4) begin
            w_temp = w_sub_out;
        end
    end

    assign w_new = w_old ^ w_temp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = EXPAND;
            EXPAND:  if (w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i    <= 6'd0;
            r_mod  <= 3'd0;
            r_rcon <= 8'h01;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_kall <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_kall <= w_load;
                        r_i    <= NK_I;
                        r_mod  <= 3'd0;
                        r_rcon <= 8'h01;
                        r_busy <= 1'b1;
                    end
                end
                EXPAND: begin
                    r_kall[word_lsb(r_i) +: 32] <= w_new;
                    r_i   <= r_i + 6'd1;
                    r_mod <= (r_mod == MOD_LAST) ? 3'd0 : r_mod + 3'd1;
                    if (r_mod == 3'd0) begin
                        r_rcon <= xtime(r_rcon);
                    end
                end
                DONE: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef AES_KS_RK_STREAM_EN
    logic         r_rk_valid;
    logic [3:0]   r_rk_idx;
    logic [127:0] r_rk;
    logic         r_rk_on;
    logic [3:0]   r_rk_next;

    assign rk_valid = r_rk_valid;
    assign rk_idx   = r_rk_idx;
    assign rk       = r_rk;

    // r_i[5:2] is the number of fully written round keys; emit one per cycle in order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rk_valid <= 1'b0;
            r_rk_idx   <= 4'd0;
            r_rk       <= '0;
            r_rk_on    <= 1'b0;
            r_rk_next  <= 4'd0;
        end else begin
            r_rk_valid <= 1'b0;
            if (r_state == IDLE && start) begin
                r_rk_on   <= 1'b1;
                r_rk_next <= 4'd0;
            end else if (r_rk_on && (r_rk_next < r_i[5:2])) begin
                r_rk_valid <= 1'b1;
                r_rk_idx   <= r_rk_next;
                r_rk       <= r_kall[{r_rk_next, 7'b0000000} +: 128];
                r_rk_next  <= r_rk_next + 4'd1;
                if (r_rk_next == 4'(NR)) begin
                    r_rk_on <= 1'b0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_aes_key_sched_fwd.sv
// Directed bench for aes_key_sched_fwd: FIPS-197 vectors for 128/192/256-bit keys,
// ignored restarts, restart after done, mid-run reset and (optionally) the round-key stream.
module tb_aes_key_sched_fwd;

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           start128, start192, start256;
    logic [127:0]   key128;
    logic [191:0]   key192;
    logic [255:0]   key256;
    logic           busy128, busy192, busy256;
    logic           done128, done192, done256;
    logic [1407:0]  kall128;
    logic [1663:0]  kall192;
    logic [1919:0]  kall256;
`ifdef AES_KS_RK_STREAM_EN
    logic           rkv128, rkv192, rkv256;
    logic [3:0]     rki128, rki192, rki256;
    logic [127:0]   rk128, rk192, rk256;
    int             rk_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    aes_key_sched_fwd #(.KEY_SIZE(128)) u_dut128 (
        .clk(clk), .rst_n(rst_n), .start(start128), .key(key128),
        .busy(busy128), .done(done128), .kall(kall128)
`ifdef AES_KS_RK_STREAM_EN
        , .rk_valid(rkv128), .rk_idx(rki128), .rk(rk128)
`endif
    );

    aes_key_sched_fwd #(.KEY_SIZE(192)) u_dut192 (
        .clk(clk), .rst_n(rst_n), .start(start192), .key(key192),
        .busy(busy192), .done(done192), .kall(kall192)
`ifdef AES_KS_RK_STREAM_EN
        , .rk_valid(rkv192), .rk_idx(rki192), .rk(rk192)
`endif
    );

    aes_key_sched_fwd #(.KEY_SIZE(256)) u_dut256 (
        .clk(clk), .rst_n(rst_n), .start(start256), .key(key256),
        .busy(busy256), .done(done256), .kall(kall256)
`ifdef AES_KS_RK_STREAM_EN
        , .rk_valid(rkv256), .rk_idx(rki256), .rk(rk256)
`endif
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Accept edge is the posedge after the negedge where start is raised.
    task automatic pulse128(input logic [127:0] k);
        @(negedge clk);
        key128   = k;
        start128 = 1'b1;
`ifdef AES_KS_RK_STREAM_EN
        rk_count = 0;
`endif
        @(negedge clk);
        start128 = 1'b0;
        key128   = ~k;
        check_eq("busy_after_accept", 128'(busy128), 128'd1);
    endtask

    // Counts negedges after the accept edge until done; re-pulses start at glitch_at.
    task automatic run128(input logic [127:0] k, input int glitch_at, output int cyc);
        pulse128(k);
        cyc = 0;
        while (!done128 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == glitch_at) begin
                start128 = 1'b1;
                key128   = 128'h0;
            end else begin
                start128 = 1'b0;
            end
        end
        start128 = 1'b0;
    endtask

`ifdef AES_KS_RK_STREAM_EN
    always @(negedge clk) begin
        if (rkv128) begin
            check_eq("rk_idx_order", 128'(rki128), 128'(rk_count));
            check_eq("rk_vs_kall", rk128, kall128[128*rki128 +: 128]);
            check_eq("rk_done_align", 128'(done128), 128'(rki128 == 4'd10));
            rk_count++;
        end
    end
`endif

    initial begin
        int cyc;
        rst_n    = 1'b0;
        start128 = 1'b0; start192 = 1'b0; start256 = 1'b0;
        key128   = '0;   key192   = '0;   key256   = '0;
`ifdef AES_KS_RK_STREAM_EN
        rk_count = 0;
`endif
        repeat (3) @(negedge clk);
        check_eq("reset_busy", 128'(busy128), 128'd0);
        check_eq("reset_done", 128'(done128), 128'd0);
        check_eq("reset_kall_nonzero", 128'(kall128 != '0), 128'd0);
        rst_n = 1'b1;

        // AES-128 reference expansion
        run128(K128, -1, cyc);
        check_eq("t1_latency", 128'(cyc), 128'd41);
        check_eq("t1_busy_at_done", 128'(busy128), 128'd0);
        check_eq("t1_round0", kall128[0 +: 128], K128);
        check_eq("t1_round1", kall128[128 +: 128], 128'ha0fafe1788542cb123a339392a6c7605);
        check_eq("t1_round2", kall128[256 +: 128], 128'hf2c295f27a96b9435935807a7359f67f);
        check_eq("t1_round10", kall128[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        @(negedge clk);
        check_eq("t1_done_one_cycle", 128'(done128), 128'd0);
        check_eq("t1_kall_held", kall128[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`ifdef AES_KS_RK_STREAM_EN
        check_eq("t6_rk_pulse_count", 128'(rk_count), 128'd11);
`endif

        // AES-192
        @(negedge clk);
        key192 = K192; start192 = 1'b1;
        @(negedge clk);
        start192 = 1'b0; key192 = '0;
        cyc = 0;
        while (!done192 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("t2_latency", 128'(cyc), 128'd47);
        check_eq("t2_round1", kall192[128 +: 128], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        check_eq("t2_round12", kall192[1536 +: 128], 128'he98ba06f448c773c8ecc720401002202);

        // AES-256, round 3 depends on the i%8==4 SubWord path
        @(negedge clk);
        key256 = K256; start256 = 1'b1;
        @(negedge clk);
        start256 = 1'b0; key256 = '0;
        cyc = 0;
        while (!done256 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("t3_latency", 128'(cyc), 128'd53);
        check_eq("t3_round3", kall256[384 +: 128], 128'ha8b09c1a93d194cdbe49846eb75d5b9a);
        check_eq("t3_round14", kall256[1792 +: 128], 128'hfe4890d1e6188d0b046df344706c631e);

        // Restart mid-run is ignored; restart right after done is accepted
        run128(K128, 10, cyc);
        check_eq("t4_latency", 128'(cyc), 128'd41);
        check_eq("t4_round1", kall128[128 +: 128], 128'ha0fafe1788542cb123a339392a6c7605);
        check_eq("t4_round10", kall128[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        run128(128'h0, -1, cyc);
        check_eq("t4_restart_latency", 128'(cyc), 128'd41);
        check_eq("t4_zero_round1", kall128[128 +: 128], 128'h62636363626363636263636362636363);
        check_eq("t4_zero_round2", kall128[256 +: 128], 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);

        // Asynchronous reset in the middle of an expansion
        pulse128(K128);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("t5_busy_in_reset", 128'(busy128), 128'd0);
        check_eq("t5_done_in_reset", 128'(done128), 128'd0);
        check_eq("t5_kall_nonzero", 128'(kall128 != '0), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run128(K128, -1, cyc);
        check_eq("t5_latency", 128'(cyc), 128'd41);
        check_eq("t5_round10", kall128[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        @(negedge clk);
`ifdef AES_KS_RK_STREAM_EN
        check_eq("t5_rk_pulse_count", 128'(rk_count), 128'd11);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
